// File: rtl/branch_flag_source.sv
// branch_flag_source: multicycle zero/MSB flag producer for the short-branch decider.
// MSB is captured on accept; zero is found by scanning CHUNK bits per cycle with
// early exit on the first nonzero chunk. Flags are held until flags_ack.
module branch_flag_source #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic             br_en,
    input  logic [1:0]       br_type,
    output logic             flags_valid,
    input  logic             flags_ack,
    output logic             zero,
    output logic             MSB,
    output logic             ShortBr,
    output logic [1:0]       ShortBrType,
    output logic             busy
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_SCAN = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_operand;
    logic             r_br_en;
    logic [1:0]       r_br_type;
    logic [IDX_W-1:0] r_idx;
    logic             r_acc;
    logic             r_zero;
    logic             r_msb;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_operand_nxt;
    logic             w_br_en_nxt;
    logic [1:0]       w_br_type_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_acc_nxt;
    logic             w_zero_nxt;
    logic             w_msb_nxt;
    logic [CHUNK-1:0] w_chunk;
    logic             w_nz;

    // Select the chunk addressed by the scan index and OR-reduce it
    always_comb begin
        w_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_chunk = r_operand[i*CHUNK +: CHUNK];
            end
        end
        w_nz = |w_chunk;
    end

    // Next-state and next-datapath values
    always_comb begin
        w_state_nxt   = r_state;
        w_operand_nxt = r_operand;
        w_br_en_nxt   = r_br_en;
        w_br_type_nxt = r_br_type;
        w_idx_nxt     = r_idx;
        w_acc_nxt     = r_acc;
        w_zero_nxt    = r_zero;
        w_msb_nxt     = r_msb;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt   = S_SCAN;
                    w_operand_nxt = operand;
                    w_br_en_nxt   = br_en;
                    w_br_type_nxt = br_type;
                    w_msb_nxt     = operand[WIDTH-1];
                    w_idx_nxt     = '0;
                    w_acc_nxt     = 1'b0;
                end
            end
            S_SCAN: begin
                if (w_nz || (r_idx == IDX_LAST)) begin
                    w_zero_nxt  = !(r_acc | w_nz);
                    w_state_nxt = S_DONE;
                end else begin
                    w_acc_nxt = r_acc | w_nz;
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (flags_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_operand <= '0;
            r_br_en   <= 1'b0;
            r_br_type <= 2'b00;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_zero    <= 1'b0;
            r_msb     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_operand <= w_operand_nxt;
            r_br_en   <= w_br_en_nxt;
            r_br_type <= w_br_type_nxt;
            r_idx     <= w_idx_nxt;
            r_acc     <= w_acc_nxt;
            r_zero    <= w_zero_nxt;
            r_msb     <= w_msb_nxt;
        end
    end

    // ShortBr is gated by flags_valid so stale flags never request a branch
    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign flags_valid = (r_state == S_DONE);
    assign ShortBr     = r_br_en & (r_state == S_DONE);
    assign ShortBrType = r_br_type;
    assign zero        = r_zero;
    assign MSB         = r_msb;

endmodule

// File: tb/tb_branch_flag_source.sv
// Directed testbench for branch_flag_source (WIDTH=32, CHUNK=8).
module tb_branch_flag_source;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] operand;
    logic        br_en;
    logic [1:0]  br_type;
    logic        flags_valid;
    logic        flags_ack;
    logic        zero;
    logic        MSB;
    logic        ShortBr;
    logic [1:0]  ShortBrType;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    branch_flag_source #(.WIDTH(32), .CHUNK(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .operand    (operand),
        .br_en      (br_en),
        .br_type    (br_type),
        .flags_valid(flags_valid),
        .flags_ack  (flags_ack),
        .zero       (zero),
        .MSB        (MSB),
        .ShortBr    (ShortBr),
        .ShortBrType(ShortBrType),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one request for a single accept edge, then count edges until flags_valid (0 = timeout)
    task automatic send(input logic [31:0] op, input logic en, input logic [1:0] typ, output int lat);
        operand   = op;
        br_en     = en;
        br_type   = typ;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (flags_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // One-cycle acknowledge pulse
    task automatic ack();
        flags_ack = 1'b1;
        @(posedge clk); #1;
        flags_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; operand = 32'h8000_0001; br_en = 1'b1; br_type = 2'b11; flags_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1)     begin failures++; $display("FAIL reset.req_ready got=%b exp=1", req_ready); end
        checks++; if (flags_valid !== 1'b0)   begin failures++; $display("FAIL reset.flags_valid got=%b exp=0", flags_valid); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset.busy got=%b exp=0", busy); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL reset.zero got=%b exp=0", zero); end
        checks++; if (MSB !== 1'b0)           begin failures++; $display("FAIL reset.MSB got=%b exp=0", MSB); end
        checks++; if (ShortBr !== 1'b0)       begin failures++; $display("FAIL reset.ShortBr got=%b exp=0", ShortBr); end
        checks++; if (ShortBrType !== 2'b00)  begin failures++; $display("FAIL reset.ShortBrType got=%b exp=00", ShortBrType); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset.release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_zero_operand();
        int lat;
        send(32'h0000_0000, 1'b1, 2'b10, lat);
        checks++; if (lat !== 4)              begin failures++; $display("FAIL zero_op.latency got=%0d exp=4", lat); end
        checks++; if (zero !== 1'b1)          begin failures++; $display("FAIL zero_op.zero got=%b exp=1", zero); end
        checks++; if (MSB !== 1'b0)           begin failures++; $display("FAIL zero_op.MSB got=%b exp=0", MSB); end
        checks++; if (ShortBr !== 1'b1)       begin failures++; $display("FAIL zero_op.ShortBr got=%b exp=1", ShortBr); end
        checks++; if (ShortBrType !== 2'b10)  begin failures++; $display("FAIL zero_op.ShortBrType got=%b exp=10", ShortBrType); end
        checks++; if (req_ready !== 1'b0)     begin failures++; $display("FAIL zero_op.req_ready got=%b exp=0", req_ready); end
        ack();
        checks++; if (flags_valid !== 1'b0)   begin failures++; $display("FAIL zero_op.post_ack_valid got=%b exp=0", flags_valid); end
        checks++; if (ShortBr !== 1'b0)       begin failures++; $display("FAIL zero_op.post_ack_ShortBr got=%b exp=0", ShortBr); end
        checks++; if (zero !== 1'b1)          begin failures++; $display("FAIL zero_op.post_ack_zero got=%b exp=1", zero); end
        checks++; if (ShortBrType !== 2'b10)  begin failures++; $display("FAIL zero_op.post_ack_type got=%b exp=10", ShortBrType); end
    endtask

    task automatic test_early_exit();
        int lat;
        send(32'h0000_0001, 1'b1, 2'b11, lat);
        checks++; if (lat !== 1)              begin failures++; $display("FAIL early.latency got=%0d exp=1", lat); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL early.zero got=%b exp=0", zero); end
        checks++; if (MSB !== 1'b0)           begin failures++; $display("FAIL early.MSB got=%b exp=0", MSB); end
        checks++; if (ShortBrType !== 2'b11)  begin failures++; $display("FAIL early.ShortBrType got=%b exp=11", ShortBrType); end
        ack();
    endtask

    task automatic test_negative();
        int lat;
        send(32'h8000_0000, 1'b1, 2'b01, lat);
        checks++; if (lat !== 4)              begin failures++; $display("FAIL negative.latency got=%0d exp=4", lat); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL negative.zero got=%b exp=0", zero); end
        checks++; if (MSB !== 1'b1)           begin failures++; $display("FAIL negative.MSB got=%b exp=1", MSB); end
        checks++; if (ShortBrType !== 2'b01)  begin failures++; $display("FAIL negative.ShortBrType got=%b exp=01", ShortBrType); end
        ack();
    endtask

    task automatic test_hold_backpressure();
        int lat;
        // First nonzero chunk is chunk 1 -> two edges
        send(32'h0000_5600, 1'b1, 2'b00, lat);
        checks++; if (lat !== 2)              begin failures++; $display("FAIL hold.latency got=%0d exp=2", lat); end
        operand = 32'h0000_1234; br_en = 1'b1; br_type = 2'b11;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i % 2 == 0);
            @(posedge clk); #1;
            checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL hold.flags_valid[%0d] got=%b exp=1", i, flags_valid); end
            checks++; if (req_ready !== 1'b0)   begin failures++; $display("FAIL hold.req_ready[%0d] got=%b exp=0", i, req_ready); end
            checks++; if (zero !== 1'b0 || MSB !== 1'b0 || ShortBrType !== 2'b00 || ShortBr !== 1'b1)
                begin failures++; $display("FAIL hold.flags[%0d] got=z%b m%b t%b s%b exp=z0 m0 t00 s1", i, zero, MSB, ShortBrType, ShortBr); end
        end
        req_valid = 1'b1;
        flags_ack = 1'b1;
        @(posedge clk); #1;
        flags_ack = 1'b0;
        checks++; if (req_ready !== 1'b1)     begin failures++; $display("FAIL hold.ack_ready got=%b exp=1", req_ready); end
        checks++; if (flags_valid !== 1'b0)   begin failures++; $display("FAIL hold.ack_valid got=%b exp=0", flags_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1)          begin failures++; $display("FAIL hold.second_accept_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (flags_valid !== 1'b1)   begin failures++; $display("FAIL hold.second_valid got=%b exp=1", flags_valid); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL hold.second_zero got=%b exp=0", zero); end
        checks++; if (ShortBrType !== 2'b11)  begin failures++; $display("FAIL hold.second_type got=%b exp=11", ShortBrType); end
        ack();
    endtask

    task automatic test_br_en_off();
        int lat;
        // Ack held during the scan must be ignored until DONE
        flags_ack = 1'b1;
        send(32'h0000_0000, 1'b0, 2'b10, lat);
        checks++; if (lat !== 4)              begin failures++; $display("FAIL br_off.latency got=%0d exp=4", lat); end
        checks++; if (zero !== 1'b1)          begin failures++; $display("FAIL br_off.zero got=%b exp=1", zero); end
        checks++; if (ShortBr !== 1'b0)       begin failures++; $display("FAIL br_off.ShortBr got=%b exp=0", ShortBr); end
        @(posedge clk); #1;
        flags_ack = 1'b0;
        checks++; if (req_ready !== 1'b1)     begin failures++; $display("FAIL br_off.ack_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        operand = 32'h0000_0000; br_en = 1'b1; br_type = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (flags_valid !== 1'b0)   begin failures++; $display("FAIL rst_mid.flags_valid got=%b exp=0", flags_valid); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL rst_mid.busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 1'b1)     begin failures++; $display("FAIL rst_mid.req_ready got=%b exp=1", req_ready); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL rst_mid.zero got=%b exp=0", zero); end
        checks++; if (MSB !== 1'b0)           begin failures++; $display("FAIL rst_mid.MSB got=%b exp=0", MSB); end
        checks++; if (ShortBrType !== 2'b00)  begin failures++; $display("FAIL rst_mid.ShortBrType got=%b exp=00", ShortBrType); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (flags_valid !== 1'b0)   begin failures++; $display("FAIL rst_mid.release_valid got=%b exp=0", flags_valid); end
        send(32'hFF00_0000, 1'b1, 2'b01, lat);
        checks++; if (lat !== 4)              begin failures++; $display("FAIL rst_mid.new_latency got=%0d exp=4", lat); end
        checks++; if (MSB !== 1'b1)           begin failures++; $display("FAIL rst_mid.new_MSB got=%b exp=1", MSB); end
        checks++; if (zero !== 1'b0)          begin failures++; $display("FAIL rst_mid.new_zero got=%b exp=0", zero); end
        ack();
    endtask

    initial begin
        test_reset();
        test_zero_operand();
        test_early_exit();
        test_negative();
        test_hold_backpressure();
        test_br_en_off();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_flag_source.md
Name: branch_flag_source

Overview:
- Multicycle condition-flag producer feeding the branch decision logic. It drives the zero, MSB, ShortBr and ShortBrType inputs of the branch decider.
- Accepts a register operand plus a short-branch request and evaluates MSB in the accept cycle.
- Detects zero serially, CHUNK bits per cycle, to keep area low in the multicycle datapath.
- Presents a stable, validated flag set and holds it until the control unit acknowledges it.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits OR-reduced per scan cycle. WIDTH must be an integer multiple of CHUNK. N = WIDTH/CHUNK.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  operand/request valid.
- req_ready  output  1  block can accept a request.
- operand  input  WIDTH  register value to evaluate.
- br_en  input  1  short-branch instruction in flight.
- br_type  input  2  branch type: 10 = on zero, 11 = on not-zero, 01 = on negative, 00 = on positive.
- flags_valid  output  1  flag set complete and stable.
- flags_ack  input  1  consumer has used the flags.
- zero  output  1  operand == 0.
- MSB  output  1  operand[WIDTH-1].
- ShortBr  output  1  br_en qualified by flags_valid.
- ShortBrType  output  2  latched br_type.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- req_ready = (state == IDLE). busy = !req_ready. flags_valid = (state == DONE).
- ShortBr = br_en_q & flags_valid. The downstream decider must never see ShortBr asserted on stale flags.
- Reset values: zero = 0, MSB = 0, ShortBrType = 00, internal br_en_q = 0, chunk index = 0, nonzero accumulator = 0, flags_valid = 0, ShortBr = 0, busy = 0.
- While rst_n is low, req_ready reads 1, but no transfer occurs.
- IDLE, on req_valid & req_ready:
  - Latch operand, br_en and br_type.
  - Register MSB <= operand[WIDTH-1].
  - Clear index and accumulator. Go to SCAN.
- SCAN, each cycle:
  - nz = |operand_q[idx*CHUNK +: CHUNK].
  - If nz or idx == N-1: register zero <= !(acc | nz), go to DONE.
  - Else: acc <= acc | nz, idx <= idx + 1.
- Latency: counted in rising edges from the accept edge to flags_valid high.
  - k+1 edges when the first nonzero chunk is k (early termination).
  - N edges for a zero operand.
  - Minimum 1 edge, maximum N edges.
- DONE:
  - zero, MSB and ShortBrType hold stable.
  - On flags_ack, go to IDLE. The next accept can happen no earlier than the edge after the ack edge. This gives a one-cycle bubble and is intended.
- flags_ack outside DONE is ignored.
- req_valid outside IDLE is ignored. The requester must hold its request; nothing is dropped or queued.
- After ack, zero, MSB and ShortBrType keep their last values, but ShortBr drops to 0 with flags_valid.
- Reset asserted mid-SCAN or mid-DONE: asynchronously abandon the operation, return to IDLE and restore reset values. No partial flags are presented after reset release.
- Index counter width: clog2(N), minimum 1 bit. It never wraps past N-1.
- N = 1 is legal: always a 1-edge latency.

Test Plan:
All cases use WIDTH = 32, CHUNK = 8.
- Zero operand: operand = 0x0000_0000, br_en = 1, br_type = 10 → flags_valid high 4 edges after accept. zero = 1, MSB = 0, ShortBr = 1, ShortBrType = 10.
- Early exit: operand = 0x0000_0001, br_type = 11 → flags_valid after 1 edge. zero = 0, MSB = 0, ShortBrType = 11.
- Negative operand: operand = 0x8000_0000, br_type = 01 → flags_valid after 4 edges. zero = 0, MSB = 1.
- Hold and backpressure: hold flags_ack = 0 for 10 cycles while pulsing req_valid with operand = 0x1234 → outputs unchanged, req_ready = 0 throughout, second request not taken. Then assert ack → IDLE, second request accepted the next edge, result zero = 0 after 1 edge.
- br_en = 0 request: operand = 0, br_en = 0 → flags_valid = 1, zero = 1, ShortBr = 0.
- Reset mid-scan: operand = 0x0000_0000, assert rst_n = 0 after 2 scan edges → immediate IDLE, flags_valid = 0, zero = 0, MSB = 0. A new request for 0xFF00_0000 after release gives MSB = 1, zero = 0 after 4 edges.
